// File: rtl/io_access_ctrl.sv
// Memory-mapped I/O access sequencer for the multicycle CPU: decodes the region,
// strobes the target device for one cycle, stalls until the device answers, and owns the countdown timer.
module io_access_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter logic [5:0]  TMR_RST = 6'd10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1s,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_stall,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  output logic [3:0]  dev_sel,
  output logic        dev_we,
  output logic [23:0] dev_addr,
  output logic [31:0] dev_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        vga_ack,
  input  logic        kbd_ready,
  input  logic [7:0]  kbd_data,
  input  logic [1:0]  ran_data
);

  localparam int unsigned     CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

  // dev_sel bit positions {kbd,ran,vga,mem}
  localparam int unsigned SEL_MEM = 0;
  localparam int unsigned SEL_VGA = 1;
  localparam int unsigned SEL_RAN = 2;
  localparam int unsigned SEL_KBD = 3;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;
  typedef enum logic [2:0] {RG_MEM, RG_VGA, RG_KBD, RG_RAN, RG_TMR, RG_NONE} region_e;

  function automatic region_e decode_region(input logic [7:0] r);
    case (r)
      8'h00:   return RG_MEM;
      8'h40:   return RG_VGA;
      8'h80:   return RG_KBD;
      8'hC0:   return RG_RAN;
      8'hE0:   return RG_TMR;
      default: return RG_NONE;
    endcase
  endfunction

  state_e        state_q,  state_d;
  region_e       region_q, region_d;
  logic          we_q,     we_d;
  logic [23:0]   addr_q,   addr_d;
  logic [31:0]   wdata_q,  wdata_d;
  logic [31:0]   rdata_q,  rdata_d;
  logic          err_q,    err_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [5:0]    timer_q,  timer_d;
  logic [3:0]    sel_c;

  // NOTE: every register is assigned with <= so all state updates use pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      region_q <= RG_NONE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      timer_q  <= TMR_RST;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      timer_q  <= timer_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    timer_d  = (tick_1s && timer_q != 6'd0) ? timer_q - 1'b1 : timer_q;
    sel_c    = '0;

    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          we_d     = cpu_we;
          addr_d   = cpu_addr[23:0];
          wdata_d  = cpu_wdata;
          region_d = decode_region(cpu_addr[31:24]);
          err_d    = 1'b0;
          state_d  = S_ISSUE;
        end
      end

      S_ISSUE: begin
        case (region_q)
          RG_MEM: begin
            sel_c[SEL_MEM] = 1'b1;
            cnt_d          = '0;
            state_d        = S_WAIT;
          end
          RG_VGA: begin
            sel_c[SEL_VGA] = 1'b1;
            cnt_d          = '0;
            state_d        = S_WAIT;
          end
          RG_KBD: begin
            // Reads strobe only when the FIFO pops, keeping one strobe per access.
            sel_c[SEL_KBD] = we_q;
            cnt_d          = '0;
            state_d        = S_WAIT;
          end
          RG_RAN: begin
            sel_c[SEL_RAN] = 1'b1;
            if (!we_q) rdata_d = {30'b0, ran_data};
            state_d        = S_DONE;
          end
          RG_TMR: begin
            if (we_q) timer_d = wdata_q[5:0];
            else      rdata_d = {26'b0, timer_q};
            state_d = S_DONE;
          end
          default: begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = S_DONE;
          end
        endcase
      end

      S_WAIT: begin
        case (region_q)
          RG_MEM, RG_VGA: begin
            if ((region_q == RG_MEM) ? mem_ack : vga_ack) begin
              if (!we_q) rdata_d = (region_q == RG_MEM) ? mem_rdata : 32'd0;
              state_d = S_DONE;
            end else if (cnt_q == CNT_LAST) begin
              err_d   = 1'b1;
              rdata_d = '0;
              state_d = S_DONE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          RG_KBD: begin
            if (we_q) begin
              state_d = S_DONE;
            end else if (kbd_ready) begin
              sel_c[SEL_KBD] = 1'b1;
              rdata_d        = {24'b0, kbd_data};
              state_d        = S_DONE;
            end
          end
          default: state_d = S_DONE;
        endcase
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign cpu_stall = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign cpu_done  = (state_q == S_DONE);
  assign cpu_err   = cpu_done && err_q;
  assign cpu_rdata = rdata_q;
  assign dev_sel   = sel_c;
  assign dev_we    = we_q && (sel_c != 4'b0000);
  assign dev_addr  = addr_q;
  assign dev_wdata = wdata_q;

endmodule

// File: tb/tb_io_access_ctrl.sv
// Directed bench for io_access_ctrl: table of single accesses with simple device responders,
// plus hand sequences for the timer, request-in-DONE and reset mid-access cases.
module tb_io_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick_1s, cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_stall, cpu_done, cpu_err;
  logic [31:0] cpu_rdata;
  logic [3:0]  dev_sel;
  logic        dev_we;
  logic [23:0] dev_addr;
  logic [31:0] dev_wdata;
  logic        mem_ack, vga_ack, kbd_ready;
  logic [31:0] mem_rdata;
  logic [7:0]  kbd_data;
  logic [1:0]  ran_data;

  always #5 clk = ~clk;

  io_access_ctrl dut (
    .clk(clk), .rst(rst), .tick_1s(tick_1s),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .dev_sel(dev_sel), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .vga_ack(vga_ack),
    .kbd_ready(kbd_ready), .kbd_data(kbd_data), .ran_data(ran_data)
  );

  // Device data is only meaningful while its handshake is high.
  assign mem_rdata = mem_ack   ? 32'h1234_5678 : 32'hA5A5_0F0F;
  assign kbd_data  = kbd_ready ? 8'h41 : 8'h00;
  assign ran_data  = 2'b10;

  localparam int BUDGET = 100;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;        // response cycle = 1+lat after accept; -1 = never
    logic [3:0]  exp_sel;
    int          exp_pulses;
    int          exp_done;
    logic        exp_err;
    logic        chk_rd;
    logic [31:0] exp_rdata;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  int tick_at  = -1;

  logic [3:0]  r_sel;
  int          r_pulses, r_done;
  logic        r_err, r_stall_ok, r_we_at;
  logic [31:0] r_rdata, r_wdata_at;
  logic [23:0] r_addr_at;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_access(input vec_t v);
    int cyc;
    logic [7:0] rg;
    rg         = v.addr[31:24];
    r_sel      = '0;
    r_pulses   = 0;
    r_done     = -1;
    r_err      = 1'b0;
    r_rdata    = '0;
    r_stall_ok = 1'b1;
    r_we_at    = 1'b0;
    r_addr_at  = '0;
    r_wdata_at = '0;
    cpu_we     = v.we;
    cpu_addr   = v.addr;
    cpu_wdata  = v.wdata;
    cpu_req    = 1'b1;
    tick_1s    = (tick_at == 0);
    step();
    cpu_req = 1'b0;
    cyc     = 1;
    forever begin
      mem_ack   = (rg == 8'h00) && v.lat >= 0 && cyc == 1 + v.lat;
      vga_ack   = (rg == 8'h40) && v.lat >= 0 && cyc == 1 + v.lat;
      kbd_ready = (rg == 8'h80) && v.lat >= 0 && cyc >= 1 + v.lat;
      tick_1s   = (cyc == tick_at);
      @(negedge clk);
      if (dev_sel != 4'b0000) begin
        r_pulses++;
        r_sel      = r_sel | dev_sel;
        r_we_at    = dev_we;
        r_addr_at  = dev_addr;
        r_wdata_at = dev_wdata;
      end
      if (cpu_done) begin
        r_done  = cyc;
        r_err   = cpu_err;
        r_rdata = cpu_rdata;
        if (cpu_stall) r_stall_ok = 1'b0;
        break;
      end
      if (!cpu_stall || cpu_err) r_stall_ok = 1'b0;
      if (cyc >= BUDGET) break;
      step();
      cyc++;
    end
    step();
    mem_ack   = 1'b0;
    vga_ack   = 1'b0;
    kbd_ready = 1'b0;
    tick_1s   = 1'b0;
  endtask

  task automatic timer_read(input string name, input logic [31:0] exp);
    vec_t v;
    v = '{1'b0, 32'hE000_0000, 32'h0, -1, 4'b0000, 0, 2, 1'b0, 1'b1, 32'h0};
    do_access(v);
    check({name, "_done"},  64'(r_done), 64'd2);
    check({name, "_rdata"}, 64'(r_rdata), 64'(exp));
  endtask

  task automatic timer_write(input logic [5:0] val);
    vec_t v;
    v = '{1'b1, 32'hE000_0000, {26'h0, val}, -1, 4'b0000, 0, 2, 1'b0, 1'b0, 32'h0};
    do_access(v);
    check("tmr_wr_done", 64'(r_done), 64'd2);
  endtask

  task automatic pulse_tick();
    tick_1s = 1'b1;
    step();
    tick_1s = 1'b0;
  endtask

  vec_t vecs[$];

  initial begin
    rst = 1'b1; tick_1s = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; mem_ack = 1'b0; vga_ack = 1'b0; kbd_ready = 1'b0;

    //               we    addr           wdata          lat  sel      pulses done err   chk   rdata
    vecs.push_back('{1'b0, 32'hE000_0000, 32'h0,         -1, 4'b0000, 0,  2,  1'b0, 1'b1, 32'd10});
    vecs.push_back('{1'b1, 32'h0000_0040, 32'hDEAD_BEEF,  2, 4'b0001, 1,  4,  1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_0100, 32'h0,          1, 4'b0001, 1,  3,  1'b0, 1'b1, 32'h1234_5678});
    vecs.push_back('{1'b0, 32'h4000_0000, 32'h0,          3, 4'b0010, 1,  5,  1'b0, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_0200, 32'h0,         16, 4'b0001, 1, 18,  1'b0, 1'b1, 32'h1234_5678});
    vecs.push_back('{1'b1, 32'h4000_0010, 32'h0000_00FF, -1, 4'b0010, 1, 18,  1'b1, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 32'hC000_0000, 32'h0,         -1, 4'b0100, 1,  2,  1'b0, 1'b1, 32'h2});
    vecs.push_back('{1'b0, 32'h0000_0300, 32'h0,          0, 4'b0001, 1, 18,  1'b1, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 32'h8000_0000, 32'h0,         51, 4'b1000, 1, 53,  1'b0, 1'b1, 32'h41});
    vecs.push_back('{1'b1, 32'hC000_0004, 32'h3,         -1, 4'b0100, 1,  2,  1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h8000_0000, 32'h55,        -1, 4'b1000, 1,  3,  1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h8000_0008, 32'h0,          1, 4'b1000, 1,  3,  1'b0, 1'b1, 32'h41});
    vecs.push_back('{1'b0, 32'h2000_0000, 32'h0,         -1, 4'b0000, 0,  2,  1'b1, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 32'hFF00_0010, 32'h1,         -1, 4'b0000, 0,  2,  1'b1, 1'b0, 32'h0});

    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", 64'(cpu_stall), 64'd0);
    check("rst_done",  64'(cpu_done),  64'd0);
    check("rst_err",   64'(cpu_err),   64'd0);
    check("rst_rdata", 64'(cpu_rdata), 64'd0);
    check("rst_sel",   64'(dev_sel),   64'd0);
    check("rst_dev",   {7'd0, dev_we, dev_addr, dev_wdata}, 64'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      do_access(vecs[i]);
      check($sformatf("v%0d_done", i),   64'(r_done),     64'(vecs[i].exp_done));
      check($sformatf("v%0d_err", i),    64'(r_err),      64'(vecs[i].exp_err));
      check($sformatf("v%0d_sel", i),    64'(r_sel),      64'(vecs[i].exp_sel));
      check($sformatf("v%0d_pulses", i), 64'(r_pulses),   64'(vecs[i].exp_pulses));
      check($sformatf("v%0d_stall", i),  64'(r_stall_ok), 64'd1);
      if (vecs[i].chk_rd)
        check($sformatf("v%0d_rdata", i), 64'(r_rdata), 64'(vecs[i].exp_rdata));
      if (vecs[i].exp_pulses > 0) begin
        check($sformatf("v%0d_dev_we", i),   64'(r_we_at),   64'(vecs[i].we));
        check($sformatf("v%0d_dev_addr", i), 64'(r_addr_at), 64'(vecs[i].addr[23:0]));
        if (vecs[i].we)
          check($sformatf("v%0d_dev_wdata", i), 64'(r_wdata_at), 64'(vecs[i].wdata));
      end
    end

    // Countdown timer: decrement per tick, saturate at zero, write beats a coincident tick.
    timer_write(6'd3);
    pulse_tick(); timer_read("tmr_a", 32'd2);
    pulse_tick(); timer_read("tmr_b", 32'd1);
    pulse_tick(); timer_read("tmr_c", 32'd0);
    pulse_tick(); pulse_tick(); timer_read("tmr_d", 32'd0);
    tick_at = 1;
    timer_write(6'd7);
    tick_at = -1;
    timer_read("tmr_wr_tick", 32'd7);

    // A request held during DONE must not start a new access.
    cpu_we = 1'b0; cpu_addr = 32'hE000_0000; cpu_req = 1'b1;
    step();
    cpu_req = 1'b0;
    step();
    check("reqdone_done", 64'(cpu_done), 64'd1);
    cpu_req = 1'b1;
    step();
    cpu_req = 1'b0;
    check("reqdone_idle", 64'(cpu_stall), 64'd0);
    step();
    check("reqdone_idle2", 64'({cpu_stall, cpu_done}), 64'd0);

    // Reset during a memory WAIT aborts with no completion and restores the timer.
    cpu_we = 1'b0; cpu_addr = 32'h0000_0500; cpu_req = 1'b1;
    step();
    cpu_req = 1'b0;
    step(); step();
    check("mrst_pre_stall", 64'(cpu_stall), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("mrst_stall", 64'(cpu_stall), 64'd0);
    check("mrst_out", {7'd0, dev_we, dev_addr, dev_wdata}, 64'd0);
    check("mrst_rdata", 64'(cpu_rdata), 64'd0);
    step();
    rst = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < 5; i++) begin
        step();
        if (cpu_done || cpu_stall) seen++;
      end
      check("mrst_no_done", 64'(seen), 64'd0);
    end
    timer_read("mrst_timer", 32'd10);

    // Reset while the keyboard becomes ready must not pop the FIFO.
    cpu_we = 1'b0; cpu_addr = 32'h8000_0000; cpu_req = 1'b1;
    step();
    cpu_req = 1'b0;
    step();
    rst = 1'b1; kbd_ready = 1'b1;
    #1;
    check("krst_sel", 64'(dev_sel), 64'd0);
    step();
    rst = 1'b0; kbd_ready = 1'b0;
    step();
    check("krst_idle", 64'({cpu_stall, cpu_done}), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
